decode_stage: RTL and testbench

Operand-decode pipeline stage sitting directly upstream of the 8-entry register file. It accepts pre-decoded instruction fields from fetch, drives the register file read ports, and bypasses in-flight results from execute, memory and writeback. It detects load-use hazards and registers a complete operand bundle for execute, using valid/ready handshakes on both sides.

---
 rtl/decode_stage_if.sv | 38 +++
 rtl/decode_stage.sv | 123 ++++++++++++
 tb/tb_decode_stage.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side bundle of the decode stage, each with a valid/ready handshake.
// master = fetch/execute environment, slave = decode_stage.
interface decode_stage_if #(
    parameter int DATA_W = 8,
    parameter int REG_W  = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [REG_W-1:0]  in_srcA;
    logic [REG_W-1:0]  in_srcB;
    logic [REG_W-1:0]  in_dstE;
    logic [REG_W-1:0]  in_dstM;
    logic [DATA_W-1:0] in_valC;

    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_op;
    logic [DATA_W-1:0] out_valA;
    logic [DATA_W-1:0] out_valB;
    logic [DATA_W-1:0] out_valC;
    logic [REG_W-1:0]  out_dstE;
    logic [REG_W-1:0]  out_dstM;

    modport master (
        output in_valid, in_op, in_srcA, in_srcB, in_dstE, in_dstM, in_valC,
        input  in_ready,
        input  out_valid, out_op, out_valA, out_valB, out_valC, out_dstE, out_dstM,
        output out_ready
    );

    modport slave (
        input  in_valid, in_op, in_srcA, in_srcB, in_dstE, in_dstM, in_valC,
        output in_ready,
        output out_valid, out_op, out_valA, out_valB, out_valC, out_dstE, out_dstM,
        input  out_ready
    );
endinterface

// File: rtl/decode_stage.sv
// Operand-decode stage: register-file read, result bypass, load-use stall, one output register.
// Latency 1 cycle; in_ready drops on output backpressure, hazard or flush. Define DECODE_FWD_EN for full bypassing.
module decode_stage #(
    parameter int DATA_W = 8,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    decode_stage_if.slave     bus,
    output logic [REG_W-1:0]  rf_srcA,
    output logic [REG_W-1:0]  rf_srcB,
    input  logic [DATA_W-1:0] rf_A,
    input  logic [DATA_W-1:0] rf_B,
    input  logic [DATA_W-1:0] ex_valE,
    input  logic              mem_valid,
    input  logic [REG_W-1:0]  mem_dstE,
    input  logic [REG_W-1:0]  mem_dstM,
    input  logic [DATA_W-1:0] mem_valE,
    input  logic [DATA_W-1:0] mem_valM,
    input  logic [REG_W-1:0]  wb_dstE,
    input  logic [REG_W-1:0]  wb_dstM,
    input  logic [DATA_W-1:0] wb_E,
    input  logic [DATA_W-1:0] wb_M,
    input  logic              flush
);
    localparam logic [REG_W-1:0] R0 = '0;

    logic              out_valid_q;
    logic [3:0]        out_op_q;
    logic [DATA_W-1:0] out_valA_q;
    logic [DATA_W-1:0] out_valB_q;
    logic [DATA_W-1:0] out_valC_q;
    logic [REG_W-1:0]  out_dstE_q;
    logic [REG_W-1:0]  out_dstM_q;

    logic              adv;
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    assign rf_srcA = bus.in_srcA;
    assign rf_srcB = bus.in_srcB;

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv && !hazard && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef DECODE_FWD_EN
    // Youngest producer first; within a stage M beats E, as in the register file.
    function automatic logic [DATA_W-1:0] pick(input logic [REG_W-1:0] src,
                                               input logic [DATA_W-1:0] rf_val);
        logic [DATA_W-1:0] v;
        if (src == R0)                                 v = '0;
        else if (out_valid_q && out_dstE_q == src)     v = ex_valE;
        else if (mem_valid && mem_dstM == src)         v = mem_valM;
        else if (mem_valid && mem_dstE == src)         v = mem_valE;
        else if (wb_dstM == src)                       v = wb_M;
        else if (wb_dstE == src)                       v = wb_E;
        else                                           v = rf_val;
        return v;
    endfunction

    always_comb begin
        op_a   = pick(bus.in_srcA, rf_A);
        op_b   = pick(bus.in_srcB, rf_B);
        // A load in execute has no data yet; only a stall resolves it.
        hazard = out_valid_q && (out_dstM_q != R0) &&
                 ((out_dstM_q == bus.in_srcA) || (out_dstM_q == bus.in_srcB));
    end
`else
    // Without bypassing, any in-flight writer of a source holds the bundle until it is in the register file.
    function automatic logic busy(input logic [REG_W-1:0] src);
        return (src != R0) &&
               ((out_valid_q && (out_dstE_q == src || out_dstM_q == src)) ||
                (mem_valid && (mem_dstE == src || mem_dstM == src)) ||
                (wb_dstE == src) || (wb_dstM == src));
    endfunction

    logic unused_fwd;
    assign unused_fwd = ^{ex_valE, mem_valE, mem_valM, wb_E, wb_M};

    always_comb begin
        op_a   = (bus.in_srcA == R0) ? '0 : rf_A;
        op_b   = (bus.in_srcB == R0) ? '0 : rf_B;
        hazard = busy(bus.in_srcA) || busy(bus.in_srcB);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_valA_q  <= '0;
            out_valB_q  <= '0;
            out_valC_q  <= '0;
            out_dstE_q  <= '0;
            out_dstM_q  <= '0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (adv) begin
            if (accept) begin
                out_valid_q <= 1'b1;
                out_op_q    <= bus.in_op;
                out_valA_q  <= op_a;
                out_valB_q  <= op_b;
                out_valC_q  <= bus.in_valC;
                out_dstE_q  <= bus.in_dstE;
                out_dstM_q  <= bus.in_dstM;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_op_q;
    assign bus.out_valA  = out_valA_q;
    assign bus.out_valB  = out_valB_q;
    assign bus.out_valC  = out_valC_q;
    assign bus.out_dstE  = out_dstE_q;
    assign bus.out_dstM  = out_dstM_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a transaction-level model.
module tb_decode_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rf_srcA, rf_srcB;
    logic [7:0] rf_A, rf_B, ex_valE, mem_valE, mem_valM, wb_E, wb_M;
    logic       mem_valid, flush;
    logic [2:0] mem_dstE, mem_dstM, wb_dstE, wb_dstM;

    int checks = 0;
    int failures = 0;

    decode_stage_if #(.DATA_W(8), .REG_W(3)) bus ();

    decode_stage #(.DATA_W(8), .REG_W(3)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rf_srcA(rf_srcA), .rf_srcB(rf_srcB), .rf_A(rf_A), .rf_B(rf_B),
        .ex_valE(ex_valE), .mem_valid(mem_valid), .mem_dstE(mem_dstE), .mem_dstM(mem_dstM),
        .mem_valE(mem_valE), .mem_valM(mem_valM), .wb_dstE(wb_dstE), .wb_dstM(wb_dstM),
        .wb_E(wb_E), .wb_M(wb_M), .flush(flush)
    );

    always #5 clk = ~clk;

    // Expected contents of the bundle currently presented to execute.
    logic       m_valid = 1'b0;
    logic [3:0] m_op = '0;
    logic [7:0] m_valA = '0, m_valB = '0, m_valC = '0;
    logic [2:0] m_dstE = '0, m_dstM = '0;

    function automatic logic [34:0] dut_vec();
        return {bus.out_valid, bus.out_op, bus.out_valA, bus.out_valB, bus.out_valC, bus.out_dstE, bus.out_dstM};
    endfunction

    function automatic logic [34:0] ref_vec();
        return {m_valid, m_op, m_valA, m_valB, m_valC, m_dstE, m_dstM};
    endfunction

    // Value an instruction reading src should see, scanning producers youngest to oldest.
    function automatic logic [7:0] ref_operand(input logic [2:0] src, input logic [7:0] rf);
        logic [7:0] v;
`ifdef DECODE_FWD_EN
        logic       wv [5];
        logic [2:0] wd [5];
        logic [7:0] wx [5];
        logic       found;
        wv[0] = m_valid;   wd[0] = m_dstE;   wx[0] = ex_valE;
        wv[1] = mem_valid; wd[1] = mem_dstM; wx[1] = mem_valM;
        wv[2] = mem_valid; wd[2] = mem_dstE; wx[2] = mem_valE;
        wv[3] = 1'b1;      wd[3] = wb_dstM;  wx[3] = wb_M;
        wv[4] = 1'b1;      wd[4] = wb_dstE;  wx[4] = wb_E;
        found = 1'b0;
        v = rf;
        for (int i = 0; i < 5; i++) begin
            if (!found && wv[i] && wd[i] == src) begin
                v = wx[i];
                found = 1'b1;
            end
        end
`else
        v = rf;
`endif
        if (src == 3'd0) v = 8'h00;
        return v;
    endfunction

    function automatic logic ref_stall();
        logic s;
`ifdef DECODE_FWD_EN
        s = m_valid && m_dstM != 3'd0 && (m_dstM == bus.in_srcA || m_dstM == bus.in_srcB);
`else
        logic [2:0] pend [$];
        if (m_valid) begin pend.push_back(m_dstE); pend.push_back(m_dstM); end
        if (mem_valid) begin pend.push_back(mem_dstE); pend.push_back(mem_dstM); end
        pend.push_back(wb_dstE);
        pend.push_back(wb_dstM);
        s = 1'b0;
        foreach (pend[i]) begin
            if (bus.in_srcA != 3'd0 && pend[i] == bus.in_srcA) s = 1'b1;
            if (bus.in_srcB != 3'd0 && pend[i] == bus.in_srcB) s = 1'b1;
        end
`endif
        return s;
    endfunction

    function automatic logic ref_in_ready();
        return (!m_valid || bus.out_ready) && !ref_stall() && !flush;
    endfunction

    // Advance one clock: apply the model's transaction rules, then step to just after the edge.
    task automatic tick();
        logic       acc, go;
        logic [7:0] a, b;
        acc = bus.in_valid && ref_in_ready();
        go  = !m_valid || bus.out_ready;
        a   = ref_operand(bus.in_srcA, rf_A);
        b   = ref_operand(bus.in_srcB, rf_B);
        if (rst) begin
            {m_valid, m_op, m_valA, m_valB, m_valC, m_dstE, m_dstM} = '0;
        end else if (flush) begin
            m_valid = 1'b0;
        end else if (go) begin
            if (acc) begin
                m_valid = 1'b1; m_op = bus.in_op; m_valA = a; m_valB = b;
                m_valC = bus.in_valC; m_dstE = bus.in_dstE; m_dstM = bus.in_dstM;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; flush = 1'b0; bus.out_ready = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_srcA = '0; bus.in_srcB = '0;
        bus.in_dstE = '0; bus.in_dstM = '0; bus.in_valC = '0;
        rf_A = '0; rf_B = '0; ex_valE = '0;
        mem_valid = 1'b0; mem_dstE = '0; mem_dstM = '0; mem_valE = '0; mem_valM = '0;
        wb_dstE = '0; wb_dstM = '0; wb_E = '0; wb_M = '0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                         input logic [2:0] de, input logic [2:0] dm, input logic [7:0] c);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_srcA = sa; bus.in_srcB = sb;
        bus.in_dstE = de; bus.in_dstM = dm; bus.in_valC = c;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        issue(4'hF, 3'd1, 3'd2, 3'd3, 3'd4, 8'hFF);
        tick();
        tick();
        checks++;
        if (dut_vec() !== 35'd0) begin failures++; $display("FAIL reset_outputs got %h want 0", dut_vec()); end
        idle();
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_basic();
        idle();
        issue(4'h3, 3'd3, 3'd0, 3'd1, 3'd0, 8'h10);
        rf_A = 8'h5A; rf_B = 8'hEE;
        #1;
        checks++;
        if (rf_srcA !== 3'd3 || rf_srcB !== 3'd0) begin failures++; $display("FAIL rf_addr got %0d/%0d want 3/0", rf_srcA, rf_srcB); end
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready got %b want 1", bus.in_ready); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_valA !== 8'h5A || bus.out_valB !== 8'h00) begin
            failures++; $display("FAIL basic_operands got v=%b A=%h B=%h want v=1 A=5a B=00", bus.out_valid, bus.out_valA, bus.out_valB);
        end
        checks++;
        if (dut_vec() !== ref_vec()) begin failures++; $display("FAIL basic_bundle got %h want %h", dut_vec(), ref_vec()); end
    endtask

    task automatic test_fwd_priority();
        idle();
        issue(4'h1, 3'd0, 3'd0, 3'd2, 3'd0, 8'h01);
        tick();
        issue(4'h2, 3'd2, 3'd0, 3'd0, 3'd0, 8'h02);
        ex_valE = 8'h11; mem_valid = 1'b1; mem_dstM = 3'd2; mem_valM = 8'h22; rf_A = 8'h99;
        #1;
        checks++;
        if (bus.in_ready !== ref_in_ready()) begin failures++; $display("FAIL prio_in_ready got %b want %b", bus.in_ready, ref_in_ready()); end
        tick();
        checks++;
        if (dut_vec() !== ref_vec()) begin failures++; $display("FAIL prio_bundle got %h want %h", dut_vec(), ref_vec()); end
`ifdef DECODE_FWD_EN
        checks++;
        if (bus.out_valA !== 8'h11) begin failures++; $display("FAIL prio_ex_first got %h want 11", bus.out_valA); end
`endif
        idle();
        tick();
        tick();
        issue(4'h4, 3'd0, 3'd4, 3'd0, 3'd0, 8'h03);
        wb_dstM = 3'd4; wb_M = 8'h33; wb_dstE = 3'd4; wb_E = 8'h44; rf_B = 8'h00;
        #1;
        checks++;
        if (bus.in_ready !== ref_in_ready()) begin failures++; $display("FAIL wb_in_ready got %b want %b", bus.in_ready, ref_in_ready()); end
        tick();
        checks++;
        if (dut_vec() !== ref_vec()) begin failures++; $display("FAIL wb_bundle got %h want %h", dut_vec(), ref_vec()); end
`ifdef DECODE_FWD_EN
        checks++;
        if (bus.out_valB !== 8'h33) begin failures++; $display("FAIL wb_m_first got %h want 33", bus.out_valB); end
`endif
    endtask

    task automatic test_load_use();
        idle();
        tick();
        issue(4'h5, 3'd0, 3'd0, 3'd0, 3'd5, 8'h05);
        tick();
        issue(4'h6, 3'd5, 3'd1, 3'd3, 3'd0, 8'h06);
        rf_A = 8'h01; rf_B = 8'h0B;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL loaduse_stall got %b want 0", bus.in_ready); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL loaduse_bubble got %b want 0", bus.out_valid); end
        mem_valid = 1'b1; mem_dstM = 3'd5; mem_valM = 8'h77;
        #1;
        checks++;
        if (bus.in_ready !== ref_in_ready()) begin failures++; $display("FAIL loaduse_release got %b want %b", bus.in_ready, ref_in_ready()); end
        tick();
        checks++;
        if (dut_vec() !== ref_vec()) begin failures++; $display("FAIL loaduse_bundle got %h want %h", dut_vec(), ref_vec()); end
`ifdef DECODE_FWD_EN
        checks++;
        if (bus.out_valA !== 8'h77) begin failures++; $display("FAIL loaduse_memM got %h want 77", bus.out_valA); end
`endif
    endtask

    task automatic test_backpressure();
        idle();
        tick();
        issue(4'h7, 3'd0, 3'd0, 3'd0, 3'd0, 8'h21);
        tick();
        issue(4'h8, 3'd1, 3'd2, 3'd6, 3'd0, 8'h42);
        rf_A = 8'hA1; rf_B = 8'hB2; bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
            ex_valE = 8'(i + 1);
            tick();
            checks++;
            if (dut_vec() !== ref_vec()) begin failures++; $display("FAIL bp_hold[%0d] got %h want %h", i, dut_vec(), ref_vec()); end
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_release got %b want 1", bus.in_ready); end
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_valA !== 8'hA1 || bus.out_valC !== 8'h42) begin
            failures++; $display("FAIL bp_accept got v=%b A=%h C=%h want v=1 A=a1 C=42", bus.out_valid, bus.out_valA, bus.out_valC);
        end
        bus.out_ready = 1'b0; flush = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flush_in_ready got %b want 0", bus.in_ready); end
        tick();
        flush = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got %b want 0", bus.out_valid); end
    endtask

    task automatic test_writer_drain();
        idle();
        tick();
        issue(4'h9, 3'd6, 3'd0, 3'd1, 3'd0, 8'h66);
        mem_valid = 1'b1; mem_dstE = 3'd6; mem_valE = 8'h5C; rf_A = 8'h00;
        for (int s = 0; s < 3; s++) begin
            if (s == 1) begin mem_valid = 1'b0; wb_dstE = 3'd6; wb_E = 8'h5C; end
            if (s == 2) begin wb_dstE = 3'd0; rf_A = 8'h5C; end
            #1;
            checks++;
            if (bus.in_ready !== ref_in_ready()) begin failures++; $display("FAIL drain_in_ready[%0d] got %b want %b", s, bus.in_ready, ref_in_ready()); end
            tick();
            checks++;
            if (dut_vec() !== ref_vec()) begin failures++; $display("FAIL drain_bundle[%0d] got %h want %h", s, dut_vec(), ref_vec()); end
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_valA !== 8'h5C) begin
            failures++; $display("FAIL drain_final got v=%b A=%h want v=1 A=5c", bus.out_valid, bus.out_valA);
        end
    endtask

    task automatic test_random();
        idle();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 9) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_op = 4'($urandom); bus.in_srcA = 3'($urandom); bus.in_srcB = 3'($urandom);
            bus.in_dstE = 3'($urandom); bus.in_dstM = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'd0;
            bus.in_valC = 8'($urandom);
            rf_A = 8'($urandom); rf_B = 8'($urandom); ex_valE = 8'($urandom);
            mem_valid = 1'($urandom); mem_dstE = 3'($urandom); mem_dstM = 3'($urandom);
            mem_valE = 8'($urandom); mem_valM = 8'($urandom);
            wb_dstE = ($urandom_range(0, 1) == 0) ? 3'($urandom) : 3'd0;
            wb_dstM = ($urandom_range(0, 1) == 0) ? 3'($urandom) : 3'd0;
            wb_E = 8'($urandom); wb_M = 8'($urandom);
            #1;
            checks++;
            if (rf_srcA !== bus.in_srcA || rf_srcB !== bus.in_srcB) begin
                failures++; $display("FAIL rand_rf_addr[%0d] got %0d/%0d want %0d/%0d", n, rf_srcA, rf_srcB, bus.in_srcA, bus.in_srcB);
            end
            checks++;
            if (bus.in_ready !== ref_in_ready()) begin failures++; $display("FAIL rand_in_ready[%0d] got %b want %b", n, bus.in_ready, ref_in_ready()); end
            tick();
            checks++;
            if (dut_vec() !== ref_vec()) begin failures++; $display("FAIL rand_bundle[%0d] got %h want %h", n, dut_vec(), ref_vec()); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fwd_priority();
        test_load_use();
        test_backpressure();
        test_writer_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
